boot_load_sequencer: RTL

// - Hardware boot loader for the debug/AXI path: halts CPU0, streams a word image into instruction

---
 rtl/boot_load_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/boot_load_sequencer.sv
// Boot loader: halts CPU0, bursts an instruction/data image over AXI4, writes the boot PC, resumes CPU0.
// Optional BOOT_SEQ_CHECKSUM_EN adds a running sum of all image beats on the checksum output.
module boot_load_sequencer #(
    parameter int unsigned MAX_BURST   = 255,
    parameter int unsigned CNT_W       = 16,
    parameter logic [31:0] PC_REG_ADDR = 32'h1A11_2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr_base,
    input  logic [CNT_W-1:0] instr_words,
    input  logic [31:0]      data_base,
    input  logic [CNT_W-1:0] data_words,
    input  logic [31:0]      boot_pc,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [31:0]      src_data,
    output logic             cpu_stall,
    input  logic             cpu_stalled,
    output logic             aw_valid,
    input  logic             aw_ready,
    output logic [31:0]      aw_addr,
    output logic [7:0]       aw_len,
    output logic [2:0]       aw_size,
    output logic [1:0]       aw_burst,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_data,
    output logic             w_last,
    output logic [3:0]       w_strb,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [1:0]       b_resp,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      checksum
);

    typedef enum logic [3:0] {
        S_IDLE, S_STALL, S_AW, S_W, S_B, S_PC_AW, S_PC_W, S_PC_B, S_RESUME, S_DONE, S_ERROR
    } state_t;

    state_t           state_q;
    logic             region_q;
    logic [31:0]      instr_base_q, data_base_q, pc_q;
    logic [CNT_W-1:0] instr_words_q, data_words_q, words_done_q;
    logic [8:0]       beat_q, beats_q;
    logic             aw_valid_q, cpu_stall_q, busy_q, done_q, error_q;
    logic [31:0]      aw_addr_q;
    logic [7:0]       aw_len_q;

    logic             start_ok, w_fire, last_beat, advance;
    logic             region_d, to_pc_d;
    logic [CNT_W-1:0] words_done_d, sum_d, sel_words, rem;
    logic [31:0]      sel_base, rem32, burst_addr_d;
    logic [8:0]       burst_beats_d;

    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    assign w_fire    = (state_q == S_W) && src_valid && w_ready;
    assign last_beat = (beat_q == beats_q - 9'd1);
    assign advance   = (state_q == S_STALL && cpu_stalled) ||
                       (state_q == S_B && b_valid && b_resp == 2'b00);

    // Pick the next burst: continue the current region, move to data, or fall through to the PC write.
    always_comb begin
        region_d     = 1'b0;
        words_done_d = '0;
        to_pc_d      = 1'b0;
        sum_d        = words_done_q + CNT_W'(beats_q);
        if (state_q == S_STALL) begin
            if (instr_words_q != '0)     region_d = 1'b0;
            else if (data_words_q != '0) region_d = 1'b1;
            else                         to_pc_d  = 1'b1;
        end else if (!region_q) begin
            if (sum_d < instr_words_q) begin
                words_done_d = sum_d;
            end else if (data_words_q != '0) begin
                region_d = 1'b1;
            end else begin
                to_pc_d = 1'b1;
            end
        end else begin
            region_d = 1'b1;
            if (sum_d < data_words_q) words_done_d = sum_d;
            else                      to_pc_d      = 1'b1;
        end
        sel_base      = region_d ? data_base_q  : instr_base_q;
        sel_words     = region_d ? data_words_q : instr_words_q;
        rem           = sel_words - words_done_d;
        rem32         = 32'(rem);
        burst_beats_d = (rem32 > 32'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(rem32);
        burst_addr_d  = sel_base + (32'(words_done_d) << 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            region_q      <= 1'b0;
            instr_base_q  <= '0;
            data_base_q   <= '0;
            pc_q          <= '0;
            instr_words_q <= '0;
            data_words_q  <= '0;
            words_done_q  <= '0;
            beat_q        <= '0;
            beats_q       <= '0;
            aw_valid_q    <= 1'b0;
            aw_addr_q     <= '0;
            aw_len_q      <= '0;
            cpu_stall_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        instr_base_q  <= instr_base;
                        instr_words_q <= instr_words;
                        data_base_q   <= data_base;
                        data_words_q  <= data_words;
                        pc_q          <= boot_pc;
                        done_q        <= 1'b0;
                        error_q       <= 1'b0;
                        cpu_stall_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_STALL;
                    end
                end
                S_AW: begin
                    if (aw_ready) begin
                        aw_valid_q <= 1'b0;
                        beat_q     <= '0;
                        state_q    <= S_W;
                    end
                end
                S_W: begin
                    if (w_fire) begin
                        beat_q <= beat_q + 9'd1;
                        if (last_beat) state_q <= S_B;
                    end
                end
                S_B: begin
                    if (b_valid && b_resp != 2'b00) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_ERROR;
                    end
                end
                S_PC_AW: begin
                    if (aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= S_PC_W;
                    end
                end
                S_PC_W: begin
                    if (w_ready) state_q <= S_PC_B;
                end
                S_PC_B: begin
                    if (b_valid) begin
                        if (b_resp != 2'b00) begin
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                            state_q <= S_ERROR;
                        end else begin
                            cpu_stall_q <= 1'b0;
                            state_q     <= S_RESUME;
                        end
                    end
                end
                S_RESUME: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: ;
            endcase
            // Shared launch path for STALL-ack and OKAY responses; overrides the case above.
            if (advance) begin
                region_q     <= region_d;
                words_done_q <= words_done_d;
                beats_q      <= to_pc_d ? 9'd1 : burst_beats_d;
                aw_valid_q   <= 1'b1;
                aw_addr_q    <= to_pc_d ? PC_REG_ADDR : burst_addr_d;
                aw_len_q     <= to_pc_d ? 8'd0 : 8'(burst_beats_d - 9'd1);
                state_q      <= to_pc_d ? S_PC_AW : S_AW;
            end
        end
    end

`ifdef BOOT_SEQ_CHECKSUM_EN
    logic [31:0] checksum_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           checksum_q <= '0;
        else if (start_ok) checksum_q <= '0;
        else if (w_fire)   checksum_q <= checksum_q + src_data;
    end
    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign src_ready = (state_q == S_W) && w_ready;
    assign w_valid   = (state_q == S_W) ? src_valid : (state_q == S_PC_W);
    assign w_data    = (state_q == S_W) ? src_data : ((state_q == S_PC_W) ? pc_q : '0);
    assign w_last    = (state_q == S_W) ? last_beat : (state_q == S_PC_W);
    assign b_ready   = (state_q == S_B) || (state_q == S_PC_B);
    assign aw_valid  = aw_valid_q;
    assign aw_addr   = aw_addr_q;
    assign aw_len    = aw_len_q;
    assign aw_size   = 3'b010;
    assign aw_burst  = 2'b01;
    assign w_strb    = 4'hF;
    assign cpu_stall = cpu_stall_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
